// File: rtl/gomoku_turn_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gomoku_turn_ctrl : human-vs-AI gomoku turn sequencer on a BOARD_N^2 board.
// Optional macro GOMOKU_HUMAN_TIMER_EN adds a human-move forfeit timer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gomoku_turn_ctrl #(
  parameter int BOARD_N       = 15,
  parameter int AI_TIMEOUT    = 1023,
  parameter int HUMAN_TIMEOUT = 50000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         restart,
  input  logic                         place,
  input  logic [3:0]                   cur_x,
  input  logic [3:0]                   cur_y,
  input  logic [BOARD_N*BOARD_N-1:0]   ai_board,
  input  logic                         ai_finish,
  input  logic [3:0]                   ai_x,
  input  logic [3:0]                   ai_y,
  output logic                         ai_enable,
  output logic                         ai_rst_n,
  output logic [BOARD_N*BOARD_N-1:0]   human_board,
  output logic                         human_turn,
  output logic                         illegal,
  output logic                         game_over,
  output logic                         fault,
  output logic [7:0]                   move_count,
  output logic [3:0]                   last_x,
  output logic [3:0]                   last_y
);

  localparam int         CELLS    = BOARD_N * BOARD_N;
  localparam int         WD_W     = $clog2(AI_TIMEOUT + 1);
  localparam logic [7:0] c_Cells  = 8'(CELLS);
  localparam logic [3:0] c_Centre = 4'(BOARD_N / 2);

  typedef enum logic [2:0] {
    OPEN       = 3'd0,
    WAIT_HUMAN = 3'd1,
    CHECK      = 3'd2,
    AI_ARM     = 3'd3,
    AI_RUN     = 3'd4,
    OVER       = 3'd5
  } state_t;

  state_t            r_state, w_stateNext;
  logic [CELLS-1:0]  r_humanBoard;
  logic [7:0]        r_moveCount;
  logic [3:0]        r_lastX, r_lastY, r_curX, r_curY;
  logic              r_fault, r_aiRstN, r_engineReady;
  logic [WD_W-1:0]   r_wdog;

  logic              w_inRange, w_legal, w_wdExpire;
  logic [7:0]        w_idx, w_countInc;
  logic              w_latchCursor, w_placeStone, w_bumpCount, w_loadLast, w_raiseFault;
  logic [3:0]        w_nextX, w_nextY;

  // The index is forced to 0 off-board so the bitmaps are never read out of range.
  assign w_inRange  = (r_curX < 4'(BOARD_N)) && (r_curY < 4'(BOARD_N));
  assign w_idx      = w_inRange ? (8'(r_curX) * 8'(BOARD_N) + 8'(r_curY)) : 8'd0;
  assign w_legal    = w_inRange && !r_humanBoard[w_idx] && !ai_board[w_idx];
  assign w_countInc = (r_moveCount == c_Cells) ? r_moveCount : r_moveCount + 8'd1;
  assign w_wdExpire = (r_wdog == WD_W'(AI_TIMEOUT - 1));

`ifdef GOMOKU_HUMAN_TIMER_EN
  logic [25:0] r_humanTimer;
  logic        w_humanExpire;
  assign w_humanExpire = (r_humanTimer == 26'(HUMAN_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_humanTimer <= '0;
    else if (restart || r_state != WAIT_HUMAN)
      r_humanTimer <= '0;
    else
      r_humanTimer <= r_humanTimer + 26'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= OPEN;
    else        r_state <= w_stateNext;
  end

  // ai_enable is combinational so it drops in the very cycle finish is consumed.
  always_comb begin
    w_stateNext   = r_state;
    ai_enable     = 1'b0;
    human_turn    = 1'b0;
    illegal       = 1'b0;
    w_latchCursor = 1'b0;
    w_placeStone  = 1'b0;
    w_bumpCount   = 1'b0;
    w_loadLast    = 1'b0;
    w_raiseFault  = 1'b0;
    w_nextX       = 4'd0;
    w_nextY       = 4'd0;
    case (r_state)
      OPEN: begin
        if (r_engineReady) begin
          if (ai_finish) begin
            w_bumpCount = 1'b1;
            w_loadLast  = 1'b1;
            w_nextX     = c_Centre;
            w_nextY     = c_Centre;
            w_stateNext = WAIT_HUMAN;
          end else begin
            ai_enable = 1'b1;
          end
        end
      end
      WAIT_HUMAN: begin
        human_turn = 1'b1;
        if (place) begin
          w_latchCursor = 1'b1;
          w_stateNext   = CHECK;
        end
`ifdef GOMOKU_HUMAN_TIMER_EN
        else if (w_humanExpire) begin
          illegal     = 1'b1;
          w_stateNext = AI_ARM;
        end
`endif
      end
      CHECK: begin
        if (w_legal) begin
          w_placeStone = 1'b1;
          w_bumpCount  = 1'b1;
          w_loadLast   = 1'b1;
          w_nextX      = r_curX;
          w_nextY      = r_curY;
          w_stateNext  = (w_countInc == c_Cells) ? OVER : AI_ARM;
        end else begin
          illegal     = 1'b1;
          w_stateNext = WAIT_HUMAN;
        end
      end
      AI_ARM: begin
        if (w_wdExpire) begin
          w_raiseFault = 1'b1;
          w_stateNext  = OVER;
        end else begin
          ai_enable = 1'b1;
          if (!ai_finish) w_stateNext = AI_RUN;
        end
      end
      AI_RUN: begin
        if (ai_finish) begin
          w_bumpCount = 1'b1;
          w_loadLast  = 1'b1;
          w_nextX     = ai_x;
          w_nextY     = ai_y;
          w_stateNext = (w_countInc == c_Cells) ? OVER : WAIT_HUMAN;
        end else if (w_wdExpire) begin
          w_raiseFault = 1'b1;
          w_stateNext  = OVER;
        end else begin
          ai_enable = 1'b1;
        end
      end
      OVER:    w_stateNext = OVER;
      default: w_stateNext = OPEN;
    endcase
    if (restart) begin
      w_stateNext = OPEN;
      ai_enable   = 1'b0;
      illegal     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_humanBoard  <= '0;
      r_moveCount   <= 8'd0;
      r_lastX       <= 4'd0;
      r_lastY       <= 4'd0;
      r_curX        <= 4'd0;
      r_curY        <= 4'd0;
      r_fault       <= 1'b0;
      r_aiRstN      <= 1'b1;
      r_engineReady <= 1'b0;
      r_wdog        <= '0;
    end else begin
      r_aiRstN      <= !restart;
      r_engineReady <= !restart;
      r_wdog        <= (r_state == AI_ARM || r_state == AI_RUN) ? r_wdog + 1'b1 : '0;
      if (restart) begin
        r_humanBoard <= '0;
        r_moveCount  <= 8'd0;
        r_lastX      <= 4'd0;
        r_lastY      <= 4'd0;
        r_fault      <= 1'b0;
      end else begin
        if (w_latchCursor) begin
          r_curX <= cur_x;
          r_curY <= cur_y;
        end
        if (w_placeStone) r_humanBoard[w_idx] <= 1'b1;
        if (w_bumpCount)  r_moveCount <= w_countInc;
        if (w_loadLast) begin
          r_lastX <= w_nextX;
          r_lastY <= w_nextY;
        end
        if (w_raiseFault) r_fault <= 1'b1;
      end
    end
  end

  assign ai_rst_n    = r_aiRstN;
  assign human_board = r_humanBoard;
  assign game_over   = (r_state == OVER);
  assign fault       = r_fault;
  assign move_count  = r_moveCount;
  assign last_x      = r_lastX;
  assign last_y      = r_lastY;

endmodule
`default_nettype wire
